// File: rtl/reg_file_pkg.sv
// Shared processor constants: register/data widths, the zero register, and
// where the rs/rt/rd fields sit in an instruction word.
package reg_file_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     word_t;

  // Destination-mux selection upstream of the register file.
  typedef enum logic {
    DST_RT = 1'b0,
    DST_RD = 1'b1
  } dst_sel_e;

  function automatic reg_addr_t dst_reg(input word_t instr, input dst_sel_e sel);
    return (sel == DST_RD) ? instr[RD_LSB +: REG_ADDR_WIDTH]
                           : instr[RT_LSB +: REG_ADDR_WIDTH];
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: one write port and two combinational read ports.
interface reg_file_if #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::REG_ADDR_WIDTH
);

  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [ADDR_WIDTH-1:0] ReadReg1;
  logic [ADDR_WIDTH-1:0] ReadReg2;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    output ReadData1, ReadData2
  );

endinterface

// File: rtl/reg_read_port.sv
// One combinational read port: 2**ADDR_WIDTH:1 select, optional same-cycle
// write forwarding, and zero forcing for register 0 and during reset.
module reg_read_port #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::REG_ADDR_WIDTH,
  parameter bit BYPASS     = 1'b1
) (
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
  input  logic                                       reset,
  input  logic [ADDR_WIDTH-1:0]                      rd_addr,
  input  logic                                       wr_en,
  input  logic [ADDR_WIDTH-1:0]                      wr_addr,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  output logic [DATA_WIDTH-1:0]                      rd_data
);

  import reg_file_pkg::*;

  always_comb begin
    rd_data = regs[rd_addr];
    if (BYPASS && wr_en && (wr_addr == rd_addr))
      rd_data = wr_data;
    // Applied last so r0 and reset override any forwarded value.
    if (reset || (rd_addr == ADDR_WIDTH'(ZERO_REG)))
      rd_data = '0;
  end

endmodule

// File: rtl/reg_file.sv
// 32-entry register file: synchronous write port with r0 hardwired to zero,
// two combinational read ports with optional write-to-read forwarding.
module reg_file #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::REG_ADDR_WIDTH,
  parameter bit BYPASS     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  rf
);

  import reg_file_pkg::*;

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic                             wr_en;

  assign wr_en = rf.RegWrite && (rf.WriteReg != ADDR_WIDTH'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (reset)
      regs <= '0;
    else if (wr_en)
      regs[rf.WriteReg] <= rf.WriteData;
  end

  reg_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_port1 (
    .regs    (regs),
    .reset   (reset),
    .rd_addr (rf.ReadReg1),
    .wr_en   (rf.RegWrite),
    .wr_addr (rf.WriteReg),
    .wr_data (rf.WriteData),
    .rd_data (rf.ReadData1)
  );

  reg_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_port2 (
    .regs    (regs),
    .reset   (reset),
    .rd_addr (rf.ReadReg2),
    .wr_en   (rf.RegWrite),
    .wr_addr (rf.WriteReg),
    .wr_data (rf.WriteData),
    .rd_data (rf.ReadData2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench driving a BYPASS=1 and a BYPASS=0 register file in lockstep.
module tb_reg_file;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_b ();
  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_n ();

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) u_byp (
    .clk   (clk),
    .reset (reset),
    .rf    (if_b)
  );

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) u_nob (
    .clk   (clk),
    .reset (reset),
    .rf    (if_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input logic en, input logic [4:0] addr, input logic [31:0] data);
    if_b.RegWrite = en; if_b.WriteReg = addr; if_b.WriteData = data;
    if_n.RegWrite = en; if_n.WriteReg = addr; if_n.WriteData = data;
  endtask

  task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
    if_b.ReadReg1 = a1; if_b.ReadReg2 = a2;
    if_n.ReadReg1 = a1; if_n.ReadReg2 = a2;
    #1;
  endtask

  // Checks both ports of both instances; expected values may differ per instance.
  task automatic check_all(input string tag,
                           input logic [31:0] b1, input logic [31:0] b2,
                           input logic [31:0] n1, input logic [31:0] n2);
    check({tag, "/byp/p1"}, if_b.ReadData1, b1);
    check({tag, "/byp/p2"}, if_b.ReadData2, b2);
    check({tag, "/nob/p1"}, if_n.ReadData1, n1);
    check({tag, "/nob/p2"}, if_n.ReadData2, n2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] addr, input logic [31:0] data);
    set_wr(1'b1, addr, data);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    set_wr(1'b1, 5'd5, 32'h1234_5678);
    set_rd(5'd5, 5'd5);
    check_all("reset_suppresses_fwd", 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    set_wr(1'b0, 5'd0, 32'h0);

    // 1. every address reads zero after reset
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      check_all($sformatf("post_reset_r%0d", a), 32'h0, 32'h0, 32'h0, 32'h0);
    end

    // 2. write/readback
    write(5'd8, 32'hDEAD_BEEF);
    write(5'd31, 32'h0000_0005);
    set_rd(5'd8, 5'd31);
    check_all("readback_r8_r31", 32'hDEAD_BEEF, 32'h5, 32'hDEAD_BEEF, 32'h5);
    set_rd(5'd9, 5'd9);
    check_all("r9_untouched", 32'h0, 32'h0, 32'h0, 32'h0);

    // 3. zero register, including same-cycle forwarding attempt
    set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(5'd0, 5'd0);
    check_all("r0_same_cycle", 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd0, 5'd0);
    check_all("r0_after_write", 32'h0, 32'h0, 32'h0, 32'h0);

    // 4. forwarding
    write(5'd5, 32'h11);
    set_wr(1'b1, 5'd5, 32'h22);
    set_rd(5'd5, 5'd5);
    check_all("fwd_before_edge", 32'h22, 32'h22, 32'h11, 32'h11);
    set_rd(5'd5, 5'd8);
    check_all("fwd_other_addr", 32'h22, 32'hDEAD_BEEF, 32'h11, 32'hDEAD_BEEF);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd5, 5'd5);
    check_all("fwd_after_edge", 32'h22, 32'h22, 32'h22, 32'h22);

    // 5. write-enable gating
    set_wr(1'b0, 5'd3, 32'h0000_ABCD);
    set_rd(5'd3, 5'd3);
    check_all("no_fwd_when_disabled", 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (4) step();
    set_rd(5'd3, 5'd3);
    check_all("r3_gated", 32'h0, 32'h0, 32'h0, 32'h0);
    set_wr(1'b0, 5'd0, 32'h0);

    // back-to-back writes to the same register
    write(5'd7, 32'hAAAA_0001);
    write(5'd7, 32'hBBBB_0002);
    set_rd(5'd7, 5'd7);
    check_all("b2b_last_wins", 32'hBBBB_0002, 32'hBBBB_0002, 32'hBBBB_0002, 32'hBBBB_0002);

    // 6. reset mid-operation
    for (int i = 1; i <= 4; i++) write(5'(i), 32'(i));
    set_rd(5'd1, 5'd4);
    check_all("loaded_r1_r4", 32'h1, 32'h4, 32'h1, 32'h4);
    reset = 1'b1;
    set_wr(1'b1, 5'd2, 32'h77);
    set_rd(5'd2, 5'd3);
    check_all("reset_high_reads", 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    set_wr(1'b0, 5'd0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      set_rd(5'(i), 5'(i));
      check_all($sformatf("cleared_r%0d", i), 32'h0, 32'h0, 32'h0, 32'h0);
    end
    set_rd(5'd8, 5'd31);
    check_all("cleared_r8_r31", 32'h0, 32'h0, 32'h0, 32'h0);
    write(5'd2, 32'h99);
    set_rd(5'd2, 5'd1);
    check_all("first_write_after_reset", 32'h99, 32'h0, 32'h99, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Register file for the single-cycle processor. It sits directly downstream of the five-bit destination mux, which picks between the instruction's rt and rd fields. The block takes that 5-bit write address, the write data from the writeback path and the write enable from control. It holds 32 general-purpose registers, with two combinational read ports feeding the ALU operand path and one synchronous write port.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, address width; must equal the destination mux output width; depth = 2**ADDR_WIDTH.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding on read ports; 0 = reads return the stored value only.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- RegWrite  input  1  write enable from control.
- WriteReg  input  ADDR_WIDTH  destination address, driven by the five-bit destination mux.
- WriteData  input  DATA_WIDTH  writeback value.
- ReadReg1  input  ADDR_WIDTH  rs address.
- ReadReg2  input  ADDR_WIDTH  rt address.
- ReadData1  output  DATA_WIDTH  contents of ReadReg1.
- ReadData2  output  DATA_WIDTH  contents of ReadReg2.

## Operation
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits each.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0 in all cases, including when bypass would otherwise apply.
- Write: at a rising edge with reset=0, RegWrite=1 and WriteReg≠0, register[WriteReg] takes WriteData. Otherwise no register changes.
- Reads are combinational:
  - ReadDataN = register[ReadRegN].
  - If BYPASS=1 and RegWrite=1 and WriteReg=ReadRegN≠0, ReadDataN = WriteData. This is the forwarding case.
- Both read ports are independent. They may address the same register, and both then return the same value.
- Reset:
  - Clears every register to 0 in the cycle it is sampled.
  - A write requested in the same cycle as reset is dropped; reset wins.
  - While reset is high, forwarding is suppressed and ReadDataN = 0 for every address.
- Out-of-range addresses cannot occur, because the width is exact. X/Z on an address is not qualified by the block.

## Timing
- Write latency: 1 clock. The value is visible from stored state immediately after the edge.
- Read latency: 0 cycles, combinational from ReadRegN, register state, and the bypass inputs when BYPASS=1.
- Output values after reset:
  - ReadData1 = ReadData2 = 0 for any address until the first write.
  - This holds until the first rising edge with reset=0, RegWrite=1 and WriteReg≠0.
- Reset asserted mid-program clears all architectural state at that edge. Execution resumes with a zeroed file on the first edge with reset=0.
- Back-to-back writes to the same address on consecutive cycles: the last write wins, with no hazard inside the block.
- A read and a write to the same address in the same cycle:
  - BYPASS=1: the read returns the new WriteData.
  - BYPASS=0: the read returns the old value; the new value appears after the edge.
- Timing path: the read mux is a 32:1 by DATA_WIDTH path. With BYPASS=1, a 5-bit compare and 2:1 mux are added after it. The single-cycle critical path budget includes this.

## Structure
- Shared processor package holds:
  - REG_ADDR_WIDTH = 5 and DATA_WIDTH = 32, which the destination mux, control and this block all use.
  - ZERO_REG = 5'd0.
  - Named constants for rs/rt/rd field positions in the instruction word.
- One sub-module is natural: reg_read_port, instantiated twice. It contains the address decode and 32:1 select, the zero-register override and the bypass compare.
- Storage and the write/reset logic live in reg_file itself.

## Test plan
1. Reset then read:
   - Stimulus: assert reset 1 cycle, then read every address on both ports.
   - Required: all reads = 0.
2. Write/readback:
   - Stimulus: write 32'hDEADBEEF to r8 and 32'h0000_0005 to r31, then read r8 on port 1 and r31 on port 2.
   - Required: exact values returned; r9 still 0.
3. Zero register:
   - Stimulus: write 32'hFFFFFFFF to r0, then read r0 on both ports.
   - Required: 0. Also, with BYPASS=1, a same-cycle write/read of r0 returns 0.
4. Forwarding:
   - Stimulus: with r5 = 32'h11, write 32'h22 to r5 and read r5 in the same cycle.
   - Required: BYPASS=1 gives 32'h22 before the edge; BYPASS=0 gives 32'h11 before the edge and 32'h22 after.
5. Write-enable gating:
   - Stimulus: RegWrite=0 with WriteReg=3 and WriteData=32'hABCD for 4 cycles.
   - Required: r3 unchanged (0).
6. Reset mid-operation:
   - Stimulus: load r1..r4 with 1..4; assert reset in the same cycle as a write of 32'h77 to r2.
   - Required: after the edge, r1..r4 = 0 and r2 ≠ 32'h77.
   - Then: the first write after reset deasserts lands normally.
